vend_coin_ctrl: RTL and testbench

- Controller in front of the vending datapath.
- Arbitrates coins from two acceptor slots (A, B) with a round-robin policy and accumulates credit.
- When credit reaches PRICE, sequences the dispenser over a req/ack handshake, then returns change over a valid/ready handshake.
- Refunds the full credit on an inactivity timeout.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_coin_ctrl_if.sv | 33 +++
 rtl/rr_arb2.sv | 26 ++
 rtl/vend_coin_ctrl.sv | 149 ++++++++++++++
 tb/tb_vend_coin_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, coin values and controller state encoding
package vend_pkg;

  localparam int COIN_W  = 2;
  localparam int VALUE_W = 5;

  typedef enum logic [COIN_W-1:0] {
    NICKEL  = 2'b00,
    DIME    = 2'b01,
    QUARTER = 2'b10,
    INVALID = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    VEND,
    CHANGE
  } vend_state_e;

  function automatic logic [VALUE_W-1:0] coin_value(coin_e c);
    case (c)
      NICKEL:  return 5'd5;
      DIME:    return 5'd10;
      QUARTER: return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_ctrl_if.sv
// rtl/vend_coin_ctrl_if.sv - coin slots, dispenser and change handshakes of the vend controller
interface vend_coin_ctrl_if
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6
);

  logic              a_valid;
  logic [COIN_W-1:0] a_coin;
  logic              a_ready;
  logic              b_valid;
  logic [COIN_W-1:0] b_coin;
  logic              b_ready;
  logic              vend_req;
  logic              vend_ack;
  logic              chg_valid;
  logic [CREDIT_W-1:0] chg_amt;
  logic              chg_ready;
  logic [CREDIT_W-1:0] credit;
  logic              busy;
  logic              reject;

  modport slave (
    input  a_valid, a_coin, b_valid, b_coin, vend_ack, chg_ready,
    output a_ready, b_ready, vend_req, chg_valid, chg_amt, credit, busy, reject
  );

  modport master (
    output a_valid, a_coin, b_valid, b_coin, vend_ack, chg_ready,
    input  a_ready, b_ready, vend_req, chg_valid, chg_amt, credit, busy, reject
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter, pointer resets to requester A
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt = r_ptr ? 2'b10 : 2'b01;
      else                o_gnt = i_req;
    end
  end

  // Priority moves to whichever slot was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_ptr <= 1'b0;
    else if (i_en && |o_gnt)  r_ptr <= o_gnt[0];
  end

endmodule

// File: rtl/vend_coin_ctrl.sv
// rtl/vend_coin_ctrl.sv - coin arbitration, credit accumulation, vend and change sequencing
module vend_coin_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6,
  parameter int TIMEOUT  = 255
) (
  input  logic clk,
  input  logic rst,
  vend_coin_ctrl_if.slave bus
);

  if (PRICE <= 0 || (PRICE % 5) != 0) begin : g_bad_price
    $error("PRICE must be a positive multiple of 5");
  end
  if ((2 ** CREDIT_W) <= (PRICE + 20)) begin : g_bad_width
    $error("CREDIT_W too narrow for PRICE+20");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [TW-1:0]       T_LAST  = TW'(TIMEOUT - 1);

  vend_state_e         r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic                r_vend_req, w_vend_req_nxt;
  logic                r_chg_valid, w_chg_valid_nxt;
  logic [CREDIT_W-1:0] r_chg_amt, w_chg_amt_nxt;
  logic                r_reject, w_reject_nxt;
  logic                r_busy;

  logic                w_accepting;
  logic [1:0]          w_gnt;
  logic                w_xfer;
  coin_e               w_coin;
  logic                w_coin_ok;
  logic [CREDIT_W-1:0] w_sum;

  // Ready is forced low during reset because the state already reads IDLE then.
  assign w_accepting = !rst && (r_state == IDLE || r_state == ACCEPT) && (r_credit < PRICE_C);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_accepting),
    .i_req ({bus.b_valid, bus.a_valid}),
    .o_gnt (w_gnt)
  );

  assign w_xfer    = |w_gnt;
  assign w_coin    = w_gnt[0] ? coin_e'(bus.a_coin) : coin_e'(bus.b_coin);
  assign w_coin_ok = w_xfer && (w_coin != INVALID);
  assign w_sum     = r_credit + CREDIT_W'(coin_value(w_coin));

  always_comb begin
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_timer_nxt     = r_timer;
    w_vend_req_nxt  = r_vend_req;
    w_chg_valid_nxt = r_chg_valid;
    w_chg_amt_nxt   = r_chg_amt;
    w_reject_nxt    = w_xfer && !w_coin_ok;
    case (r_state)
      IDLE, ACCEPT: begin
        if (w_xfer) begin
          w_timer_nxt = '0;
          if (w_coin_ok) begin
            w_credit_nxt = w_sum;
            if (w_sum >= PRICE_C) begin
              w_state_nxt    = VEND;
              w_vend_req_nxt = 1'b1;
            end else begin
              w_state_nxt = ACCEPT;
            end
          end
        end else if (r_state == ACCEPT) begin
          if (r_timer == T_LAST) begin
            // Refund pays out the whole credit, so the credit register empties.
            w_state_nxt     = CHANGE;
            w_chg_valid_nxt = 1'b1;
            w_chg_amt_nxt   = r_credit;
            w_credit_nxt    = '0;
            w_timer_nxt     = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
      end
      VEND: begin
        if (bus.vend_ack) begin
          w_vend_req_nxt = 1'b0;
          w_credit_nxt   = '0;
          if (r_credit == PRICE_C) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt     = CHANGE;
            w_chg_valid_nxt = 1'b1;
            w_chg_amt_nxt   = r_credit - PRICE_C;
          end
        end
      end
      CHANGE: begin
        if (r_chg_valid && bus.chg_ready) begin
          w_state_nxt     = IDLE;
          w_chg_valid_nxt = 1'b0;
          w_chg_amt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_credit    <= '0;
      r_timer     <= '0;
      r_vend_req  <= 1'b0;
      r_chg_valid <= 1'b0;
      r_chg_amt   <= '0;
      r_reject    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_credit    <= w_credit_nxt;
      r_timer     <= w_timer_nxt;
      r_vend_req  <= w_vend_req_nxt;
      r_chg_valid <= w_chg_valid_nxt;
      r_chg_amt   <= w_chg_amt_nxt;
      r_reject    <= w_reject_nxt;
      r_busy      <= (w_state_nxt == VEND) || (w_state_nxt == CHANGE);
    end
  end

  assign bus.a_ready   = w_gnt[0];
  assign bus.b_ready   = w_gnt[1];
  assign bus.vend_req  = r_vend_req;
  assign bus.chg_valid = r_chg_valid;
  assign bus.chg_amt   = r_chg_amt;
  assign bus.credit    = r_credit;
  assign bus.busy      = r_busy;
  assign bus.reject    = r_reject;

endmodule

// File: tb/tb_vend_coin_ctrl.sv
// tb/tb_vend_coin_ctrl.sv - directed and randomized checks of vend_coin_ctrl
module tb_vend_coin_ctrl;

  localparam int PRICE = 15;
  localparam int CW    = 6;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  vend_coin_ctrl_if #(.CREDIT_W(CW)) vif ();

  vend_coin_ctrl #(.PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  function automatic int val(input int code);
    case (code)
      0:       return 5;
      1:       return 10;
      2:       return 25;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit slot_b, input logic [1:0] code, input string tag);
    if (slot_b) begin
      vif.b_valid = 1'b1;
      vif.b_coin  = code;
    end else begin
      vif.a_valid = 1'b1;
      vif.a_coin  = code;
    end
    #1;
    chk({tag, "_ready"}, slot_b ? vif.b_ready : vif.a_ready, 1);
    tick();
    vif.a_valid = 1'b0;
    vif.b_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum, ca, cb, g, code, last_gnt;
    bit va, vb;

    vif.a_valid = 1'b1; vif.a_coin = 2'b00;
    vif.b_valid = 1'b1; vif.b_coin = 2'b00;
    vif.vend_ack = 1'b0; vif.chg_ready = 1'b0;
    #1;
    chk("rst_a_ready", vif.a_ready, 0);
    chk("rst_b_ready", vif.b_ready, 0);
    chk("rst_credit", vif.credit, 0);
    chk("rst_vend_req", vif.vend_req, 0);
    chk("rst_chg_valid", vif.chg_valid, 0);
    chk("rst_chg_amt", vif.chg_amt, 0);
    chk("rst_busy", vif.busy, 0);
    chk("rst_reject", vif.reject, 0);
    vif.a_valid = 1'b0; vif.b_valid = 1'b0;
    #20;
    rst = 1'b0;
    tick();

    // exact price: 10c on A then 5c on B
    put(0, 2'b01, "t1_a");
    chk("t1_credit10", vif.credit, 10);
    chk("t1_no_req", vif.vend_req, 0);
    put(1, 2'b00, "t1_b");
    chk("t1_credit15", vif.credit, 15);
    chk("t1_vend_req", vif.vend_req, 1);
    chk("t1_busy", vif.busy, 1);
    vif.a_valid = 1'b1;
    #1;
    chk("t1_no_ready_vend", vif.a_ready, 0);
    vif.a_valid = 1'b0;
    tick();
    chk("t1_req_held", vif.vend_req, 1);
    vif.vend_ack = 1'b1;
    tick();
    vif.vend_ack = 1'b0;
    chk("t1_req_drop", vif.vend_req, 0);
    chk("t1_no_chg", vif.chg_valid, 0);
    chk("t1_credit0", vif.credit, 0);
    chk("t1_idle_busy", vif.busy, 0);

    // overpay: 10c then 25c, change of 20 held under backpressure
    put(0, 2'b01, "t2_a10");
    put(0, 2'b10, "t2_a25");
    chk("t2_credit35", vif.credit, 35);
    chk("t2_vend_req", vif.vend_req, 1);
    vif.vend_ack = 1'b1;
    tick();
    vif.vend_ack = 1'b0;
    chk("t2_credit0", vif.credit, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_chg_valid", vif.chg_valid, 1);
      chk("t2_chg_amt", vif.chg_amt, 20);
      tick();
    end
    vif.chg_ready = 1'b1;
    tick();
    vif.chg_ready = 1'b0;
    chk("t2_chg_done", vif.chg_valid, 0);
    chk("t2_amt_clr", vif.chg_amt, 0);
    chk("t2_busy", vif.busy, 0);

    // contention after reset: A, B, then alternation with invalid coins
    pulse_reset();
    vif.a_valid = 1'b1; vif.b_valid = 1'b1;
    vif.a_coin = 2'b00; vif.b_coin = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        vif.a_coin = 2'b11; vif.b_coin = 2'b11;
      end
      #1;
      chk("t3_a_ready", vif.a_ready, (i % 2) == 0);
      chk("t3_b_ready", vif.b_ready, (i % 2) == 1);
      tick();
      chk("t3_credit", vif.credit, (i == 0) ? 5 : 10);
      chk("t3_reject", vif.reject, i >= 2);
    end
    vif.a_valid = 1'b0; vif.b_valid = 1'b0;

    // invalid coin from idle
    pulse_reset();
    put(1, 2'b11, "t4_b");
    chk("t4_reject", vif.reject, 1);
    chk("t4_credit", vif.credit, 0);
    tick();
    chk("t4_reject_end", vif.reject, 0);
    repeat (TMO + 2) tick();
    chk("t4_still_idle", vif.chg_valid, 0);
    chk("t4_not_busy", vif.busy, 0);

    // timeout refund, then a coin on the expiring cycle
    put(0, 2'b00, "t5_a");
    chk("t5_credit5", vif.credit, 5);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      chk("t5_refund_time", vif.chg_valid, i == TMO);
    end
    chk("t5_refund_amt", vif.chg_amt, 5);
    chk("t5_credit_clr", vif.credit, 0);
    vif.chg_ready = 1'b1;
    tick();
    vif.chg_ready = 1'b0;
    chk("t5_refund_done", vif.chg_valid, 0);
    put(0, 2'b00, "t5_b");
    repeat (TMO - 1) tick();
    chk("t5_pre_expire", vif.chg_valid, 0);
    put(0, 2'b00, "t5_late");
    chk("t5_coin_wins", vif.chg_valid, 0);
    chk("t5_credit10", vif.credit, 10);
    repeat (TMO - 1) tick();
    chk("t5_timer_restart", vif.chg_valid, 0);
    tick();
    chk("t5_refund2", vif.chg_valid, 1);
    chk("t5_refund2_amt", vif.chg_amt, 10);
    vif.chg_ready = 1'b1;
    tick();
    vif.chg_ready = 1'b0;

    // async reset in the middle of a vend
    put(0, 2'b10, "t6_a");
    chk("t6_vend_req", vif.vend_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req_async", vif.vend_req, 0);
    chk("t6_credit_async", vif.credit, 0);
    chk("t6_busy_async", vif.busy, 0);
    vif.a_valid = 1'b1; vif.b_valid = 1'b1;
    #1;
    chk("t6_a_ready_rst", vif.a_ready, 0);
    chk("t6_b_ready_rst", vif.b_ready, 0);
    vif.a_valid = 1'b0; vif.b_valid = 1'b0;
    #1;
    rst = 1'b0;
    tick();

    // randomized purchases against a coin-sum model
    last_gnt = 1;
    for (int p = 0; p < 40; p++) begin
      sum = 0;
      while (sum < PRICE) begin
        repeat ($urandom_range(0, 3)) tick();
        ca = $urandom_range(0, 3);
        cb = $urandom_range(0, 3);
        case ($urandom_range(0, 2))
          0:       begin va = 1'b1; vb = 1'b0; end
          1:       begin va = 1'b0; vb = 1'b1; end
          default: begin va = 1'b1; vb = 1'b1; end
        endcase
        vif.a_valid = va; vif.a_coin = 2'(ca);
        vif.b_valid = vb; vif.b_coin = 2'(cb);
        #1;
        g = (va && vb) ? 1 - last_gnt : (va ? 0 : 1);
        chk("rnd_a_ready", vif.a_ready, g == 0);
        chk("rnd_b_ready", vif.b_ready, g == 1);
        code = (g == 0) ? ca : cb;
        last_gnt = g;
        tick();
        vif.a_valid = 1'b0; vif.b_valid = 1'b0;
        sum += val(code);
        chk("rnd_reject", vif.reject, code == 3);
        chk("rnd_credit", vif.credit, sum);
        chk("rnd_vend_req", vif.vend_req, sum >= PRICE);
      end
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("rnd_req_held", vif.vend_req, 1);
      end
      vif.vend_ack = 1'b1;
      tick();
      vif.vend_ack = 1'b0;
      chk("rnd_req_drop", vif.vend_req, 0);
      chk("rnd_credit0", vif.credit, 0);
      chk("rnd_chg_valid", vif.chg_valid, sum > PRICE);
      chk("rnd_chg_amt", vif.chg_amt, (sum > PRICE) ? sum - PRICE : 0);
      if (sum > PRICE) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          chk("rnd_chg_hold", vif.chg_amt, sum - PRICE);
        end
        vif.chg_ready = 1'b1;
        tick();
        vif.chg_ready = 1'b0;
        chk("rnd_chg_done", vif.chg_valid, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
